adder_result_collector: RTL and testbench
=========================================

Name: adder_result_collector

Overview:
- Downstream stage of the 64-bit pipelined adder. Captures every valid adder result (result/o_en pair) into a small FIFO.
- Presents results to the consumer through a valid/ready handshake.
- The adder has no backpressure, so this block drives almost_full back to the operand source to throttle i_en.
- Results arriving when the FIFO is full are dropped, flagged in a sticky overflow bit and counted.

Parameters:
- DATA_W, 66, width of an adder result word (bit 64 = carry, bit 65 spare).
- DEPTH, 8, FIFO entries; power of two, >= 4.
- AFULL_LVL, 5, almost_full asserts when level >= AFULL_LVL. Must leave headroom for results already in flight in the adder pipeline.

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  result strobe from adder o_en
- in_data  in  DATA_W  adder result word
- out_valid  out  1  head entry available
- out_ready  in  1  consumer accepts head this cycle
- out_data  out  DATA_W  head entry (first-word fall-through)
- out_carry  out  1  out_data[64], convenience copy
- level  out  $clog2(DEPTH)+1  number of stored entries
- almost_full  out  1  level >= AFULL_LVL
- overflow  out  1  sticky: a result was dropped
- drop_cnt  out  16  saturating count of dropped results
- clr_ovf  in  1  synchronous clear of overflow and drop_cnt

Behaviour:
- Reset (async, rst_n=0) forces the following; all entries become invalid, and RAM contents need not be reset:
  - write ptr, read ptr, level = 0
  - out_valid = 0, out_data = 0, out_carry = 0
  - almost_full = 0, overflow = 0, drop_cnt = 0
- Push = in_valid && (level < DEPTH || pop).
- Pop = out_valid && out_ready.
- Storage: circular buffer indexed by write/read pointers of width $clog2(DEPTH). Pointers wrap from DEPTH-1 to 0.
- level update per cycle: +1 on push only, -1 on pop only, unchanged on both or neither. Never exceeds DEPTH and never goes below 0.
- Latency: a word pushed in cycle N is visible on out_data with out_valid=1 from cycle N+1 when the FIFO was empty. Otherwise it becomes visible after all earlier words have popped.
- out_data/out_valid are registered outputs.
- out_data holds stable while out_valid=1 and out_ready=0.
- Order is preserved exactly; no reordering, no duplication.
- Full with in_valid=1 and pop=1 in the same cycle: the push is accepted, no drop, level stays DEPTH.
- Full with in_valid=1 and no pop: the word is discarded, overflow <= 1, drop_cnt <= drop_cnt+1 (saturating at 16'hFFFF).
- Empty with in_valid=1 and out_ready=1: no bypass. The word appears the next cycle, since pop requires out_valid already high.
- out_ready ignored while out_valid=0.
- almost_full is derived combinationally from registered level, so it is glitch-free relative to the clk edge.
- clr_ovf=1 clears overflow and drop_cnt next edge.
  - If a drop occurs in the same cycle as clr_ovf, the drop wins: overflow=1, drop_cnt=1.
- in_data is sampled only when in_valid=1; X on in_data with in_valid=0 must not propagate.
- Reset mid-operation: all queued results are lost; the outputs return to their reset values immediately (asynchronously).
- Target size: 150-250 lines RTL.

Test Plan:
- Single push, DEPTH=8: reset, then in_valid=1 with in_data=66'h1_FFFF_FFFF_FFFF_FFFE for one cycle, out_ready=1 -> next cycle out_valid=1, out_carry=1, level=1; following cycle out_valid=0, level=0.
- Fill with backpressure: out_ready=0, push 8 words 0..7 on consecutive cycles.
  - almost_full rises the cycle after the 5th push (level=5); level=8 after the 8th push.
  - A 9th push gives overflow=1, drop_cnt=1.
  - Then out_ready=1 drains exactly 0..7 in order.
- Simultaneous push/pop at full: level=8, in_valid=1, out_ready=1 -> no drop, level stays 8, head advances, new word lands at the tail.
- Drop counter: hold full with out_ready=0 and in_valid=1 for 70000 cycles -> drop_cnt saturates at 16'hFFFF. clr_ovf=1 one cycle with in_valid=0 -> overflow=0, drop_cnt=0. clr_ovf with a concurrent drop -> drop_cnt=1.
- Wrap-around: stream 40 words with randomized out_ready (~50%) while keeping level below 8 -> output sequence equals input sequence, no drops, pointers wrap ≥4 times.
- Async reset mid-stream: with level=3, assert rst_n=0 between clock edges -> out_valid, level, almost_full go 0 immediately. After release, the first new push appears next cycle with no stale data.

Source files
------------

// File: rtl/adder_result_collector.sv
// Purpose : collects valid 64-bit adder results into a circular FIFO and hands them to a consumer.
// Latency : a word pushed into an empty FIFO is on out_data/out_valid the next cycle (registered, no bypass).
// Backpress: the adder cannot stall, so almost_full throttles the source; words arriving when full are dropped.
//
// Ports:
//   clk, rst_n            clock (rising edge) and asynchronous active-low reset
//   in_valid, in_data     result strobe and word from the adder (bit 64 = carry)
//   out_valid, out_ready  consumer handshake; out_data is the registered head, out_carry = out_data[64]
//   level, almost_full    occupancy and early-throttle flag (level >= AFULL_LVL)
//   overflow, drop_cnt    sticky drop flag and saturating drop count, cleared by clr_ovf
module adder_result_collector #(
    parameter int DATA_W    = 66,
    parameter int DEPTH     = 8,
    parameter int AFULL_LVL = 5
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    input  logic [DATA_W-1:0]        in_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DATA_W-1:0]        out_data,
    output logic                     out_carry,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     almost_full,
    output logic                     overflow,
    output logic [15:0]              drop_cnt,
    input  logic                     clr_ovf
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam logic [LVL_W-1:0] DEPTH_L = LVL_W'(DEPTH);
    localparam logic [LVL_W-1:0] AFULL_L = LVL_W'(AFULL_LVL);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;

    logic              pop;
    logic              push;
    logic              drop;
    logic              full;
    logic [LVL_W-1:0]  level_after_pop;
    logic [LVL_W-1:0]  level_nxt;
    logic [PTR_W-1:0]  rd_ptr_nxt;
    logic [DATA_W-1:0] head_nxt;

    always_comb begin
        pop             = out_valid && out_ready;
        full            = (level == DEPTH_L);
        // A pop in the same cycle frees the slot, so a full FIFO can still accept.
        push            = in_valid && (!full || pop);
        drop            = in_valid && full && !pop;
        level_after_pop = pop ? level - LVL_W'(1) : level;
        level_nxt       = push ? level_after_pop + LVL_W'(1) : level_after_pop;
        rd_ptr_nxt      = pop ? rd_ptr + PTR_W'(1) : rd_ptr;
        // If the FIFO is (or becomes) empty, the incoming word becomes the new head directly;
        // otherwise the next head is already sitting in the RAM.
        if (push && (level_after_pop == '0)) begin
            head_nxt = in_data;
        end else begin
            head_nxt = mem[rd_ptr_nxt];
        end
    end

    // RAM contents carry no reset; validity is tracked by the pointers and level.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= in_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            level     <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            rd_ptr    <= rd_ptr_nxt;
            level     <= level_nxt;
            out_valid <= (level_nxt != '0);
            // Only load a real entry; when draining to empty the last word is simply held.
            if (level_nxt != '0) begin
                out_data <= head_nxt;
            end
        end
    end

    // A drop in the same cycle as a clear wins, so the event is never lost.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow <= 1'b0;
            drop_cnt <= '0;
        end else if (drop) begin
            overflow <= 1'b1;
            if (clr_ovf) begin
                drop_cnt <= 16'd1;
            end else if (drop_cnt != 16'hFFFF) begin
                drop_cnt <= drop_cnt + 16'd1;
            end
        end else if (clr_ovf) begin
            overflow <= 1'b0;
            drop_cnt <= '0;
        end
    end

    assign almost_full = (level >= AFULL_L);
    assign out_carry   = out_data[64];

endmodule

// File: tb/tb_adder_result_collector.sv
// Purpose : directed bench for adder_result_collector (DEPTH=8, AFULL_LVL=5).
// Latency : observations are taken 1 time unit after each rising edge.
// Backpress: out_ready is driven directly by the stimulus sequence.
module tb_adder_result_collector;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [65:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [65:0] out_data;
    logic        out_carry;
    logic [3:0]  level;
    logic        almost_full;
    logic        overflow;
    logic [15:0] drop_cnt;
    logic        clr_ovf;

    int passed = 0;
    int total  = 0;

    adder_result_collector #(.DATA_W(66), .DEPTH(8), .AFULL_LVL(5)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_carry   (out_carry),
        .level       (level),
        .almost_full (almost_full),
        .overflow    (overflow),
        .drop_cnt    (drop_cnt),
        .clr_ovf     (clr_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [65:0] obs, input logic [65:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic fill8(input logic [65:0] base);
        out_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1;
            in_data  = base + 66'(i);
            step();
        end
        in_valid = 1'b0;
    endtask

    logic [65:0] q [$];
    logic [65:0] w;
    int          sent;
    int          got;
    int          cnt;
    bit          rdy;
    bit          pu;
    bit          po;

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0; clr_ovf = 1'b0;
        #22;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_carry", out_carry, 0);
        chk("rst_level", level, 0);
        chk("rst_afull", almost_full, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_drop_cnt", drop_cnt, 0);
        rst_n = 1'b1;
        step();

        // Single push with carry set; no bypass, visible next cycle.
        in_valid = 1'b1; in_data = 66'h1_FFFF_FFFF_FFFF_FFFE; out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        chk("single_valid", out_valid, 1);
        chk("single_carry", out_carry, 1);
        chk("single_data", out_data, 66'h1_FFFF_FFFF_FFFF_FFFE);
        chk("single_level", level, 1);
        step();
        chk("single_drain_valid", out_valid, 0);
        chk("single_drain_level", level, 0);

        // Fill with backpressure; head must hold at word 0.
        out_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1;
            in_data  = 66'(i);
            step();
            chk("fill_level", level, 66'(i + 1));
            chk("fill_afull", almost_full, (i + 1) >= 5);
            chk("fill_head_hold", out_data, 0);
        end
        in_data = 66'h99;
        step();
        in_valid = 1'b0;
        chk("ovf_flag", overflow, 1);
        chk("ovf_cnt", drop_cnt, 1);
        chk("ovf_level", level, 8);
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            chk("drain_valid", out_valid, 1);
            chk("drain_data", out_data, 66'(i));
            step();
        end
        out_ready = 1'b0;
        chk("drain_empty", out_valid, 0);
        chk("drain_level", level, 0);
        clr_ovf = 1'b1;
        step();
        clr_ovf = 1'b0;
        chk("clr_overflow", overflow, 0);
        chk("clr_drop_cnt", drop_cnt, 0);

        // Simultaneous push and pop while full.
        fill8(66'h10);
        chk("full_level", level, 8);
        in_valid = 1'b1; in_data = 66'h18; out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        chk("pp_level", level, 8);
        chk("pp_no_ovf", overflow, 0);
        chk("pp_no_drop", drop_cnt, 0);
        for (int i = 0; i < 8; i++) begin
            chk("pp_drain", out_data, 66'h11 + 66'(i));
            step();
        end
        out_ready = 1'b0;
        chk("pp_empty", level, 0);

        // Drop counter saturation and clear.
        fill8(66'h20);
        in_valid = 1'b1; in_data = 66'h3_0000_0000_0000_0000;
        repeat (70000) @(posedge clk);
        #1;
        chk("sat_cnt", drop_cnt, 16'hFFFF);
        chk("sat_ovf", overflow, 1);
        in_valid = 1'b0; clr_ovf = 1'b1;
        step();
        chk("sat_clr_ovf", overflow, 0);
        chk("sat_clr_cnt", drop_cnt, 0);
        in_valid = 1'b1;
        step();
        in_valid = 1'b0; clr_ovf = 1'b0;
        chk("clr_drop_ovf", overflow, 1);
        chk("clr_drop_cnt", drop_cnt, 1);
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            chk("sat_drain", out_data, 66'h20 + 66'(i));
            step();
        end
        out_ready = 1'b0;
        clr_ovf = 1'b1;
        step();
        clr_ovf = 1'b0;

        // Wrap-around stream with random out_ready, level kept below 8.
        sent = 0; got = 0; cnt = 0;
        for (int cyc = 0; cyc < 2000 && got < 40; cyc++) begin
            rdy = 1'($urandom_range(0, 1));
            pu  = (sent < 40) && (cnt < 7);
            po  = (cnt > 0) && rdy;
            chk("wrap_valid", out_valid, cnt > 0);
            if (po) begin
                chk("wrap_data", out_data, q[0]);
                void'(q.pop_front());
                got++;
            end
            w = {sent[1:0], $urandom(), $urandom()};
            in_valid  = pu;
            in_data   = pu ? w : 'x;
            out_ready = rdy;
            if (pu) begin
                q.push_back(w);
                sent++;
            end
            cnt = cnt + int'(pu) - int'(po);
            step();
        end
        in_valid = 1'b0; out_ready = 1'b0;
        chk("wrap_got_all", got, 40);
        chk("wrap_no_ovf", overflow, 0);
        chk("wrap_no_drop", drop_cnt, 0);
        chk("wrap_level", level, 0);

        // Asynchronous reset mid-stream.
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_data  = 66'h30 + 66'(i);
            step();
        end
        in_valid = 1'b0;
        chk("pre_rst_level", level, 3);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_valid", out_valid, 0);
        chk("arst_level", level, 0);
        chk("arst_afull", almost_full, 0);
        chk("arst_data", out_data, 0);
        #2 rst_n = 1'b1;
        step();
        in_valid = 1'b1; in_data = 66'h55; out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        chk("post_rst_valid", out_valid, 1);
        chk("post_rst_data", out_data, 66'h55);
        chk("post_rst_level", level, 1);
        step();
        chk("post_rst_empty", out_valid, 0);
        chk("post_rst_level0", level, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
